// File: rtl/keypad_encoder_pkg.sv
// Shared definitions for the 4x4 keypad encoder: key codes, FSM state encoding,
// the row/column key map and small bit-pattern helpers.
package keypad_encoder_pkg;

  localparam logic [3:0] KEY_0         = 4'h0;
  localparam logic [3:0] KEY_1         = 4'h1;
  localparam logic [3:0] KEY_2         = 4'h2;
  localparam logic [3:0] KEY_3         = 4'h3;
  localparam logic [3:0] KEY_4         = 4'h4;
  localparam logic [3:0] KEY_5         = 4'h5;
  localparam logic [3:0] KEY_6         = 4'h6;
  localparam logic [3:0] KEY_7         = 4'h7;
  localparam logic [3:0] KEY_8         = 4'h8;
  localparam logic [3:0] KEY_9         = 4'h9;
  localparam logic [3:0] KEY_DIVMOD    = 4'hA;
  localparam logic [3:0] KEY_TIMES     = 4'hB;
  localparam logic [3:0] KEY_PLUSMINUS = 4'hC;
  localparam logic [3:0] KEY_RSVD      = 4'hD;
  localparam logic [3:0] KEY_ANS       = 4'hE;
  localparam logic [3:0] KEY_EQU       = 4'hF;

  localparam logic [2:0] ST_SCAN     = 3'd0;
  localparam logic [2:0] ST_DEBOUNCE = 3'd1;
  localparam logic [2:0] ST_SETUP    = 3'd2;
  localparam logic [2:0] ST_STROBE   = 3'd3;
  localparam logic [2:0] ST_HOLD     = 3'd4;
  localparam logic [2:0] ST_REJECT   = 3'd5;

  // Indexed [row][col]; ascending ranges so the table reads like the keypad face.
  localparam logic [0:3][0:3][3:0] KEY_MAP = '{
    '{KEY_1,   KEY_2, KEY_3,   KEY_DIVMOD},
    '{KEY_4,   KEY_5, KEY_6,   KEY_TIMES},
    '{KEY_7,   KEY_8, KEY_9,   KEY_PLUSMINUS},
    '{KEY_ANS, KEY_0, KEY_EQU, KEY_RSVD}
  };

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } key_pos_t;

  function automatic logic [2:0] low_count(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, ~v[i]};
    end
    return n;
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
      else       idx = idx;
    end
    return idx;
  endfunction

  function automatic logic [3:0] key_code(input logic [3:0] row_pat, input logic [3:0] col_pat);
    return KEY_MAP[low_index(row_pat)][low_index(col_pat)];
  endfunction

endpackage

// File: rtl/keypad_encoder_if.sv
// Keypad-side bus of the encoder: row sense, column drive and key-event outputs.
interface keypad_encoder_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [4:0] eBCD;
  logic       key_err;

  modport master (output row, input col, input eBCD, input key_err);
  modport slave  (input row, output col, output eBCD, output key_err);
endinterface

// File: rtl/keypad_encoder_debounce.sv
// Row synchronizer plus a saturating counter of consecutive cycles the
// synchronized rows equal a target pattern.
module keypad_debounce
  import keypad_encoder_pkg::*;
#(
  parameter int DEB_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_async,
  input  logic [3:0] target,
  input  logic       clear,
  output logic [3:0] row_sync,
  output logic       match,
  output logic       stable
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [3:0]    sync_a;
  logic [3:0]    sync_b;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 4'h0;
      sync_b <= 4'h0;
    end else begin
      sync_a <= row_async;
      sync_b <= sync_a;
    end
  end

  assign row_sync = sync_b;
  assign match    = (sync_b == target);

  // Consecutive-match counter; saturates so a long hold never wraps
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || !match) begin
      cnt <= '0;
    end else if (cnt != CNT_LAST) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= cnt;
    end
  end

  // The current cycle is the DEB_CYCLES-th consecutive match
  assign stable = match && (cnt == CNT_LAST);

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner/encoder with debounce, setup/strobe key events and
// multi-key rejection. Optional auto-repeat is enabled with KEYPAD_AUTOREPEAT_EN.
module keypad_encoder
  import keypad_encoder_pkg::*;
#(
  parameter int SCAN_DIV      = 1000,
  parameter int DEB_CYCLES    = 20000,
  parameter int STROBE_CYCLES = 16
) (
  input  logic              sw_clk,
  input  logic              rst,
  keypad_encoder_if.slave   bus
);

  localparam int SCW = $clog2(SCAN_DIV);
  localparam int STW = $clog2(STROBE_CYCLES + 1);
  localparam logic [SCW-1:0] SCAN_LAST   = SCW'(SCAN_DIV - 1);
  localparam logic [STW-1:0] STROBE_LAST = STW'(STROBE_CYCLES - 1);

  logic [2:0]     state;
  logic [2:0]     state_next;
  logic [SCW-1:0] scan_cnt;
  logic [STW-1:0] strobe_cnt;
  logic [3:0]     col;
  logic [4:0]     ebcd;
  logic           key_err;
  key_pos_t       key_pos;

  logic [3:0]     row_sync;
  logic [3:0]     deb_target;
  logic           deb_clear;
  logic           deb_match;
  logic           deb_stable;
  logic [2:0]     lows;
  logic           slot_end;
  logic           strobe_last;
  logic           rep_fire;

  keypad_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk       (sw_clk),
    .rst       (rst),
    .row_async (bus.row),
    .target    (deb_target),
    .clear     (deb_clear),
    .row_sync  (row_sync),
    .match     (deb_match),
    .stable    (deb_stable)
  );

  assign lows        = low_count(row_sync);
  assign slot_end    = (scan_cnt == SCAN_LAST);
  assign strobe_last = (strobe_cnt == STROBE_LAST);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(256 * SCAN_DIV);
  localparam logic [RW-1:0] REP_FIRST = RW'(256 * SCAN_DIV - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(64 * SCAN_DIV - 1);

  logic [RW-1:0] rep_cnt;
  logic          rep_again;
  logic          held;

  assign held     = (row_sync == key_pos.row);
  assign rep_fire = (state == ST_HOLD) && held &&
                    (rep_cnt == (rep_again ? REP_NEXT : REP_FIRST));

  // Repeat timer runs only while the original key stays down in HOLD
  always_ff @(posedge sw_clk) begin
    if (rst) begin
      rep_cnt   <= '0;
      rep_again <= 1'b0;
    end else begin
      if (state == ST_HOLD && held && !rep_fire) rep_cnt <= rep_cnt + RW'(1);
      else                                       rep_cnt <= '0;
      if (state == ST_SCAN) rep_again <= 1'b0;
      else if (rep_fire)    rep_again <= 1'b1;
      else                  rep_again <= rep_again;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Next-state decode; the debounce counter restarts on every state change
  always_comb begin
    state_next = state;
    deb_target = 4'hF;
    deb_clear  = 1'b0;
    case (state)
      ST_SCAN: begin
        if (slot_end && lows == 3'd1)      state_next = ST_DEBOUNCE;
        else if (slot_end && lows >= 3'd2) state_next = ST_REJECT;
        else                               state_next = ST_SCAN;
      end
      ST_DEBOUNCE: begin
        deb_target = key_pos.row;
        if (!deb_match)     state_next = ST_SCAN;
        else if (deb_stable) state_next = ST_SETUP;
        else                state_next = ST_DEBOUNCE;
      end
      ST_SETUP: begin
        state_next = ST_STROBE;
      end
      ST_STROBE: begin
        if (strobe_last) state_next = ST_HOLD;
        else             state_next = ST_STROBE;
      end
      ST_HOLD: begin
        if (deb_stable)    state_next = ST_SCAN;
        else if (rep_fire) state_next = ST_SETUP;
        else               state_next = ST_HOLD;
      end
      ST_REJECT: begin
        if (deb_stable) state_next = ST_SCAN;
        else            state_next = ST_REJECT;
      end
      default: begin
        state_next = ST_SCAN;
      end
    endcase
    deb_clear = (state_next != state);
  end

  // State, scan/strobe counters, column drive and latched key position
  always_ff @(posedge sw_clk) begin
    if (rst) begin
      state      <= ST_SCAN;
      scan_cnt   <= '0;
      strobe_cnt <= '0;
      col        <= 4'b1110;
      key_pos    <= '{row: 4'hF, col: 4'b1110};
    end else begin
      state <= state_next;

      if (state == ST_SCAN && !slot_end) scan_cnt <= scan_cnt + SCW'(1);
      else                               scan_cnt <= '0;

      if (state == ST_SCAN && slot_end && lows == 3'd0) col <= {col[2:0], col[3]};
      else                                             col <= col;

      if (state == ST_SCAN && slot_end && lows == 3'd1) key_pos <= '{row: row_sync, col: col};
      else                                             key_pos <= key_pos;

      if (state == ST_STROBE && !strobe_last) strobe_cnt <= strobe_cnt + STW'(1);
      else                                    strobe_cnt <= '0;
    end
  end

  // Key event outputs: code lands one cycle ahead of the strobe rising edge
  always_ff @(posedge sw_clk) begin
    if (rst) begin
      ebcd    <= 5'b0_0000;
      key_err <= 1'b0;
    end else begin
      if (state_next == ST_SETUP && state != ST_SETUP)
        ebcd <= {1'b0, key_code(key_pos.row, key_pos.col)};
      else if (state == ST_SETUP)
        ebcd <= {1'b1, ebcd[3:0]};
      else if (state == ST_STROBE && strobe_last)
        ebcd <= {1'b0, ebcd[3:0]};
      else
        ebcd <= ebcd;
      key_err <= (state_next == ST_REJECT);
    end
  end

  assign bus.col     = col;
  assign bus.eBCD    = ebcd;
  assign bus.key_err = key_err;

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed self-checking bench for keypad_encoder with a behavioural 4x4 key matrix.
module tb_keypad_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] keys = 16'h0000;
  logic [3:0]  row_m;

  int n_tests = 0;
  int n_fail  = 0;

  int       strobe_events = 0;
  logic [3:0] rise_code = 4'h0;
  logic [3:0] pre_code  = 4'h0;
  int       last_width = 0;
  int       width_run  = 0;
  logic     prev_strobe = 1'b0;
  logic [3:0] prev_code = 4'h0;

  keypad_encoder_if bus();

  keypad_encoder #(
    .SCAN_DIV      (4),
    .DEB_CYCLES    (8),
    .STROBE_CYCLES (3)
  ) dut (
    .sw_clk (clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // A row reads low when any pressed key in it sits on the driven column
  always_comb begin
    row_m = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row_m[r] = ~|(keys[r*4 +: 4] & ~bus.col);
    end
  end
  assign bus.row = row_m;

  // Strobe monitor: counts events, code at rise, code the cycle before, width
  always @(negedge clk) begin
    if (bus.eBCD[4] && !prev_strobe) begin
      strobe_events = strobe_events + 1;
      rise_code = bus.eBCD[3:0];
      pre_code  = prev_code;
      width_run = 1;
    end else if (bus.eBCD[4]) begin
      width_run = width_run + 1;
    end else if (prev_strobe) begin
      last_width = width_run;
    end
    prev_strobe = bus.eBCD[4];
    prev_code   = bus.eBCD[3:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press(input int r, input int c);
    keys[r*4 + c] = 1'b1;
  endtask

  task automatic wait_strobe(input int target, input string tag);
    for (int i = 0; i < 300 && strobe_events < target; i++) tick();
    check(tag, 32'(strobe_events >= target), 32'd1);
  endtask

  task automatic wait_col(input logic [3:0] target, input string tag);
    for (int i = 0; i < 40 && bus.col != target; i++) tick();
    check(tag, 32'(bus.col), 32'(target));
  endtask

  task automatic col_change(output int cycles);
    logic [3:0] prev;
    prev = bus.col;
    cycles = 0;
    for (int i = 0; i < 40 && bus.col == prev; i++) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    int base;
    int cyc;
    logic [3:0] c_exp;

    // Reset state
    tick(3);
    check("rst_col", 32'(bus.col), 32'h0000000E);
    check("rst_ebcd", 32'(bus.eBCD), 32'h0);
    check("rst_key_err", 32'(bus.key_err), 32'h0);
    rst = 1'b0;

    // Column rotation, one slot every 4 cycles
    col_change(cyc);
    for (int k = 0; k < 4; k++) begin
      c_exp = {bus.col[2:0], bus.col[3]};
      col_change(cyc);
      check("scan_col", 32'(bus.col), 32'(c_exp));
      check("scan_period", 32'(cyc), 32'd4);
    end

    // Single key 2 (row0/col1)
    base = strobe_events;
    press(0, 1);
    wait_strobe(base + 1, "k2_strobe_seen");
    tick(30);
    keys = 16'h0000;
    tick(40);
    check("k2_events", 32'(strobe_events - base), 32'd1);
    check("k2_code", 32'(rise_code), 32'h2);
    check("k2_setup_code", 32'(pre_code), 32'h2);
    check("k2_width", 32'(last_width), 32'd3);
    check("k2_code_hold", 32'(bus.eBCD), 32'h02);

    // Bouncy press of row3/col2, then stable
    base = strobe_events;
    wait_col(4'b1011, "bnc_col_wait");
    for (int k = 0; k < 3; k++) begin
      press(3, 2);
      tick(3);
      keys = 16'h0000;
      tick(3);
    end
    press(3, 2);
    wait_strobe(base + 1, "bnc_strobe_seen");
    tick(20);
    keys = 16'h0000;
    tick(30);
    check("bnc_events", 32'(strobe_events - base), 32'd1);
    check("bnc_code", 32'(rise_code), 32'hF);

    // Glitch shorter than the debounce window
    base = strobe_events;
    wait_col(4'b1011, "gl_col_wait");
    press(3, 2);
    tick(5);
    keys = 16'h0000;
    tick(40);
    check("gl_events", 32'(strobe_events - base), 32'd0);

    // Two keys in column 0: reject, then recover
    base = strobe_events;
    wait_col(4'b1110, "mk_col_wait");
    press(0, 0);
    press(1, 0);
    for (int i = 0; i < 60 && !bus.key_err; i++) tick();
    check("mk_key_err", 32'(bus.key_err), 32'h1);
    tick(20);
    check("mk_key_err_held", 32'(bus.key_err), 32'h1);
    check("mk_col_frozen", 32'(bus.col), 32'hE);
    keys = 16'h0000;
    tick(16);
    check("mk_key_err_clr", 32'(bus.key_err), 32'h0);
    check("mk_events", 32'(strobe_events - base), 32'd0);
    col_change(cyc);
    check("mk_scan_resume", 32'(cyc < 40), 32'd1);

    // Reset during strobe cycle 2 with key 5 held
    base = strobe_events;
    press(1, 1);
    wait_strobe(base + 1, "rs_strobe_seen");
    check("rs_first_code", 32'(rise_code), 32'h5);
    tick();
    check("rs_pre_strobe", 32'(bus.eBCD[4]), 32'h1);
    rst = 1'b1;
    tick();
    check("rs_ebcd", 32'(bus.eBCD), 32'h0);
    check("rs_col", 32'(bus.col), 32'hE);
    rst = 1'b0;
    wait_strobe(base + 2, "rs_restrobe_seen");
    check("rs_recode", 32'(rise_code), 32'h5);
    tick(10);
    keys = 16'h0000;
    tick(30);
    check("rs_events", 32'(strobe_events - base), 32'd2);

    // Long hold of key 5
    base = strobe_events;
    press(1, 1);
    tick(1400);
    keys = 16'h0000;
    tick(30);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("ar_events", 32'(strobe_events - base), 32'd3);
`else
    check("ar_events", 32'(strobe_events - base), 32'd1);
`endif
    check("ar_code", 32'(rise_code), 32'h5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 SCAN_DIV, 1000, sw_clk cycles each column stays driven during scan (min 4).
REQ-002 DEB_CYCLES, 20000, consecutive stable cycles required for press and for release (min 2).
REQ-003 STROBE_CYCLES, 16, cycles eBCD[4] is held high per key event (min 1).
REQ-004 sw_clk  input  1  system clock; all logic on rising edge; one clock, synchronous active-high reset.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 row  input  4  keypad rows, active-low, asynchronous to sw_clk.
REQ-007 col  output  4  keypad column drive, one-hot active-low.
REQ-008 eBCD  output  5  key event: [4] strobe, [3:0] key code.
REQ-009 key_err  output  1  high while a multi-key press is being rejected.

Function
REQ-010 Row inputs SHALL pass a 2-FF synchronizer; all decisions use the synchronized value (2-cycle latency).
REQ-011 States SHALL be SCAN, DEBOUNCE, SETUP, STROBE, HOLD, REJECT.
REQ-012 SCAN: col SHALL rotate 1110→1101→1011→0111→1110, advancing every SCAN_DIV cycles.
REQ-013 SCAN: in the last cycle of a column slot, exactly one low row SHALL latch (row,col) and enter DEBOUNCE with col frozen; two or more low rows SHALL enter REJECT.
REQ-014 DEBOUNCE: if synchronized row equals the latched pattern for DEB_CYCLES consecutive cycles, go to SETUP; any mismatch SHALL return to SCAN with no event.
REQ-015 SETUP (1 cycle): eBCD[3:0] SHALL load the key code with eBCD[4]=0, so the code is stable before the strobe rising edge.
REQ-016 STROBE: eBCD[4] SHALL be 1 for exactly STROBE_CYCLES cycles, then 0; eBCD[3:0] SHALL hold the last code until the next SETUP.
REQ-017 HOLD: wait until row==4'hF for DEB_CYCLES consecutive cycles, then SCAN; a second key pressed during HOLD SHALL produce no event.
REQ-018 REJECT: key_err=1, no strobe; exit to SCAN after row==4'hF for DEB_CYCLES consecutive cycles (col frozen).
REQ-019 Key map (row0..3 × col0..3): 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D; A=div/mod, B=times, C=plus/minus, E=ans, F=equals, D=reserved (still emitted).
REQ-020 Exactly one strobe per debounced press; counters SHALL saturate or clear, never wrap into a false event.

Reset
REQ-021 On rst: state=SCAN, col=4'b1110, eBCD=5'b0_0000, key_err=0, all counters and synchronizer flops cleared.
REQ-022 rst asserted mid-strobe SHALL drop eBCD[4] on the next edge; a still-held key afterwards SHALL be re-detected as a new press.

Configuration
REQ-023 KEYPAD_AUTOREPEAT_EN defined: in HOLD, a key held for 256×SCAN_DIV cycles SHALL re-enter SETUP, then repeat every 64×SCAN_DIV cycles while held; undefined: exactly one event per press, no repeat logic synthesized.

Structure
REQ-024 Shared package: key code constants (KEY_0..KEY_9, KEY_DIVMOD=4'hA, KEY_TIMES=4'hB, KEY_PLUSMINUS=4'hC, KEY_RSVD=4'hD, KEY_ANS=4'hE, KEY_EQU=4'hF), state encoding, 4×4 key-map table.
REQ-025 One sub-module, keypad_debounce (synchronizer + stable-count comparator), instantiated once.

Verification (SCAN_DIV=4, DEB_CYCLES=8, STROBE_CYCLES=3)
REQ-026 Hold row=4'b1110 while col=4'b1101 for 20 cycles → eBCD[3:0]=4'h2 one cycle before eBCD[4] high for exactly 3 cycles, then one strobe only.
REQ-027 Press row3/col2 with 3-cycle bounce glitches, then stable → exactly one event with code 4'hF; glitch-only press (<8 cycles) → no event.
REQ-028 row=4'b1100 while col0 driven → key_err=1, no strobe; release 8 cycles → key_err=0, scanning resumes.
REQ-029 rst pulsed during strobe cycle 2 → eBCD=0 next edge, col=4'b1110; key still held → new event with the same code.
REQ-030 With KEYPAD_AUTOREPEAT_EN, hold key 5 for 1400 cycles → first strobe, then repeats at 1024+8 and every 256 cycles; without macro → single strobe.
